// File: rtl/imem_boot_ctrl_pkg.sv
// rtl/imem_boot_ctrl_pkg.sv - shared types and constants for the instruction-memory boot controller
package imem_boot_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE
    } boot_state_t;

    localparam int          BOOT_LEN_BYTES = 4;
    localparam logic [31:0] FETCH_OOR_FILL = 32'h0;

    // Replace one little-endian byte lane of a word
    function automatic logic [31:0] put_byte(input logic [31:0] w,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/imem_boot_ctrl_byte_packer.sv
// rtl/imem_boot_ctrl_byte_packer.sv - assembles four boot bytes into a little-endian word
module byte_packer
    import imem_boot_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [31:0] acc;

    // The completing byte is folded in combinationally so the length is usable in its own cycle
    assign word       = load ? put_byte(acc, cnt, data) : acc;
    assign word_valid = load && (cnt == 2'(BOOT_LEN_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
            acc <= 32'd0;
        end else if (clear) begin
            cnt <= 2'd0;
            acc <= 32'd0;
        end else if (load) begin
            cnt <= cnt + 2'd1;
            acc <= word;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - shares the instruction-memory port between fetch and a serial boot loader
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        if_req,
    input  logic [31:0] if_adr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic [31:0] mem_adr,
    output logic        mem_load,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    output logic        boot_busy,
    output logic        boot_done,
    output logic        boot_err
);

    boot_state_t state;
    logic [31:0] wptr;
    logic [31:0] remaining;

    logic        pk_clear;
    logic        pk_load;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic        len_zero;
    logic        len_over;
    logic        last_word;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .load       (pk_load),
        .data       (rx_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    assign len_zero  = (pk_word == 32'd0);
    assign len_over  = (pk_word > 32'(MEM_SIZE));
    assign last_word = (remaining == 32'd1);

    assign rx_ready  = (state == ST_LEN) || (state == ST_DATA);
    assign pk_load   = rx_ready && rx_valid;
    assign if_gnt    = if_req && (state == ST_IDLE) && !boot_start;
    assign boot_busy = (state != ST_IDLE);
    assign boot_done = ((state == ST_LEN) && pk_valid && len_zero) ||
                       ((state == ST_WRITE) && last_word);
    assign boot_err  = (state == ST_LEN) && pk_valid && len_over;
    assign mem_load  = (state == ST_WRITE);
    assign mem_in    = (state == ST_WRITE) ? pk_word : 32'd0;

    always_comb begin
        mem_adr = 32'd0;
        if (state == ST_WRITE) begin
            mem_adr = wptr;
        end else if (if_gnt) begin
            mem_adr = if_adr;
        end
    end

    // Counter restarts on entry to LEN and whenever a new data word begins
    always_comb begin
        pk_clear = 1'b0;
        case (state)
            ST_IDLE:  pk_clear = boot_start;
            ST_LEN:   pk_clear = pk_valid && !len_zero && !len_over;
            ST_WRITE: pk_clear = !last_word;
            default:  pk_clear = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wptr      <= 32'd0;
            remaining <= 32'd0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'd0;
        end else begin
            if_rvalid <= if_gnt;
            if (if_gnt) begin
                if_rdata <= (if_adr < 32'(MEM_SIZE)) ? mem_out : FETCH_OOR_FILL;
            end
            case (state)
                ST_IDLE: begin
                    if (boot_start) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (pk_valid) begin
                        if (len_zero || len_over) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_DATA;
                            wptr      <= 32'd0;
                            remaining <= pk_word;
                        end
                    end
                end
                ST_DATA: begin
                    if (pk_valid) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wptr      <= wptr + 32'd1;
                    remaining <= remaining - 32'd1;
                    state     <= last_word ? ST_IDLE : ST_DATA;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - self-checking bench for imem_boot_ctrl
module tb_imem_boot_ctrl;

    localparam int MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        boot_start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        if_req = 1'b0;
    logic [31:0] if_adr = 32'd0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic [31:0] mem_adr;
    logic        mem_load;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        boot_busy;
    logic        boot_done;
    logic        boot_err;

    imem_boot_ctrl #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_start (boot_start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .if_req     (if_req),
        .if_adr     (if_adr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_adr    (mem_adr),
        .mem_load   (mem_load),
        .mem_in     (mem_in),
        .mem_out    (mem_out),
        .boot_busy  (boot_busy),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    always #5 clk = ~clk;

    logic [31:0] phys    [MEM_SIZE];
    logic [31:0] ref_mem [MEM_SIZE];
    logic [31:0] wbuf    [MEM_SIZE];
    logic [31:0] wq_adr  [$];
    logic [31:0] wq_dat  [$];

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int busy_cycles = 0;
    bit prev_final  = 1'b0;

    assign mem_out = (mem_adr < MEM_SIZE) ? phys[mem_adr[9:0]] : 32'hdead_beef;

    always @(posedge clk) begin
        if (mem_load && mem_adr < MEM_SIZE) phys[mem_adr[9:0]] <= mem_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            busy_cycles += int'(boot_busy);
            if (boot_done) done_cnt++;
            if (boot_err) err_cnt++;
            if (prev_final) check1("busy_after_last_write", boot_busy, 1'b0);
            prev_final = mem_load && boot_done;
            if (mem_load) begin
                wq_adr.push_back(mem_adr);
                wq_dat.push_back(mem_in);
                check1("rx_ready_in_write", rx_ready, 1'b0);
                check1("gnt_with_load", if_gnt, 1'b0);
            end
            if (if_gnt) check1("gnt_only_idle", boot_busy, 1'b0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n = 0;
        if (stall) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check1("rx_ready_timeout", 1'b0, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
    endtask

    // Expected behaviour derived from the length rule: accept 1..MEM_SIZE words, N==0 done only, else error
    task automatic run_load(input logic [31:0] n, input bit stall, input bit do_start);
        int d0, e0, exp_writes, m;
        bit ok_len;
        ok_len     = (n != 0) && (n <= MEM_SIZE);
        exp_writes = ok_len ? int'(n) : 0;
        d0 = done_cnt;
        e0 = err_cnt;
        wq_adr.delete();
        wq_dat.delete();
        if (do_start) begin
            busy_cycles = 0;
            boot_start = 1'b1;
            @(negedge clk);
            boot_start = 1'b0;
        end
        send_word(n, stall);
        for (int i = 0; i < exp_writes; i++) send_word(wbuf[i], stall);
        repeat (2) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), (n <= MEM_SIZE) ? 32'd1 : 32'd0);
        check("err_pulses", 32'(err_cnt - e0), (n > MEM_SIZE) ? 32'd1 : 32'd0);
        check("write_count", 32'(wq_adr.size()), 32'(exp_writes));
        m = (wq_adr.size() < exp_writes) ? wq_adr.size() : exp_writes;
        for (int i = 0; i < m; i++) begin
            check("write_adr", wq_adr[i], 32'(i));
            check("write_data", wq_dat[i], wbuf[i]);
        end
        for (int i = 0; i < exp_writes; i++) ref_mem[i] = wbuf[i];
        check1("idle_after_load", boot_busy, 1'b0);
        if (!stall) check("load_cycles", 32'(busy_cycles), 32'(4 + 5 * exp_writes));
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
        int n = 0;
        if_adr = a;
        if_req = 1'b1;
        #1;
        while (!if_gnt && n < 200) begin
            @(negedge clk);
            n++;
        end
        check1("fetch_grant", n < 200, 1'b1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        check1("fetch_rvalid", if_rvalid, 1'b1);
        check(tag, if_rdata, exp);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    int          wn;
    int          d_arb;
    logic [31:0] a;
    bit          st;

    initial begin
        #12;
        check1("rst_rx_ready", rx_ready, 1'b0);
        check1("rst_if_gnt", if_gnt, 1'b0);
        check1("rst_if_rvalid", if_rvalid, 1'b0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_adr", mem_adr, 32'd0);
        check1("rst_mem_load", mem_load, 1'b0);
        check("rst_mem_in", mem_in, 32'd0);
        check1("rst_boot_busy", boot_busy, 1'b0);
        check1("rst_boot_done", boot_done, 1'b0);
        check1("rst_boot_err", boot_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // nominal single word: 01 00 00 00, 13 00 00 00
        wbuf[0] = 32'h0000_0013;
        run_load(32'd1, 1'b0, 1'b1);

        // three words with rx_valid toggling
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        run_load(32'd3, 1'b1, 1'b1);

        // length rule boundaries
        run_load(32'h0000_0401, 1'b0, 1'b1);
        run_load(32'hffff_ffff, 1'b0, 1'b1);
        run_load(32'd0, 1'b0, 1'b1);
        for (int i = 0; i < MEM_SIZE; i++) wbuf[i] = $urandom;
        run_load(32'd1024, 1'b0, 1'b1);

        // fetch pass-through
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(0, MEM_SIZE - 1));
            fetch(a, ref_mem[a[9:0]], "fetch_rdata");
        end
        fetch(32'd1023, ref_mem[1023], "fetch_top_word");
        fetch(32'd1024, 32'd0, "fetch_oor_1024");
        fetch(32'd2000, 32'd0, "fetch_oor_2000");

        // fetch held during a load is only granted once idle
        for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
        d_arb = done_cnt;
        fork
            run_load(32'd2, 1'b1, 1'b1);
            begin
                repeat (3) @(negedge clk);
                if_adr = 32'd5;
                if_req = 1'b1;
                wn = 0;
                while (!if_gnt && wn < 300) begin
                    @(negedge clk);
                    wn++;
                end
                check1("arb_grant_seen", wn < 300, 1'b1);
                check("arb_grant_after_done", 32'(done_cnt - d_arb), 32'd1);
                @(posedge clk);
                #1;
                if_req = 1'b0;
                check1("arb_rvalid", if_rvalid, 1'b1);
                check("arb_rdata", if_rdata, ref_mem[5]);
            end
        join
        @(negedge clk);

        // boot_start wins over a same-cycle fetch
        busy_cycles = 0;
        boot_start = 1'b1;
        if_adr = 32'd3;
        if_req = 1'b1;
        #1;
        check1("start_vs_fetch_gnt", if_gnt, 1'b0);
        @(posedge clk);
        #1;
        check1("start_vs_fetch_len", rx_ready, 1'b1);
        check1("start_vs_fetch_rvalid", if_rvalid, 1'b0);
        boot_start = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        run_load(32'd0, 1'b0, 1'b0);

        // reset after two words of a four-word load
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        d_arb = done_cnt;
        boot_start = 1'b1;
        @(negedge clk);
        boot_start = 1'b0;
        send_word(32'd4, 1'b0);
        send_word(wbuf[0], 1'b0);
        send_word(wbuf[1], 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check1("mid_rst_rx_ready", rx_ready, 1'b0);
        check1("mid_rst_if_gnt", if_gnt, 1'b0);
        check1("mid_rst_if_rvalid", if_rvalid, 1'b0);
        check("mid_rst_if_rdata", if_rdata, 32'd0);
        check("mid_rst_mem_adr", mem_adr, 32'd0);
        check1("mid_rst_mem_load", mem_load, 1'b0);
        check("mid_rst_mem_in", mem_in, 32'd0);
        check1("mid_rst_boot_busy", boot_busy, 1'b0);
        check1("mid_rst_boot_done", boot_done, 1'b0);
        check1("mid_rst_boot_err", boot_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - d_arb), 32'd0);
        check("mid_rst_word0", phys[0], wbuf[0]);
        check("mid_rst_word1", phys[1], wbuf[1]);
        ref_mem[0] = wbuf[0];
        ref_mem[1] = wbuf[1];

        // fresh load afterwards
        wn = int'($urandom_range(2, 6));
        st = 1'($urandom_range(0, 1));
        for (int i = 0; i < wn; i++) wbuf[i] = $urandom;
        run_load(32'(wn), st, 1'b1);
        fetch(32'd1, ref_mem[1], "post_rst_fetch");
        fetch(32'(wn + 3), ref_mem[wn + 3], "post_rst_fetch_old");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
